// File: rtl/v_pkg.sv
// v_pkg: shared unit-select and sequencer-state encodings for the vector issue sequencer.
package v_pkg;
  typedef enum logic [2:0] {
    U_CONFIG, U_ALU, U_MUL, U_SLDU, U_RED, U_LOAD, U_STORE, U_NONE
  } unit_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_e;
  localparam int TIMEOUT_DEFAULT = 255;
  function automatic logic writes_back(unit_e u);
    return !(u == U_STORE || u == U_NONE);
  endfunction
endpackage

// File: rtl/v_issue_fifo.sv
// v_issue_fifo: power-of-two instruction queue with synchronous push/pop and occupancy count.
module v_issue_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/v_issue_seq.sv
// v_issue_seq: vector issue sequencer, queue plus IDLE/ISSUE/WAIT/WB FSM.
// Define CARRD_SEQ_TIMEOUT_EN to enable the WAIT-state watchdog and timeout_err.
module v_issue_seq
  import v_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [2:0]  unit_sel,
  input  logic        done_valu,
  input  logic        done_vmul,
  input  logic        done_vsldu,
  input  logic        done_vred,
  input  logic        l_done,
  input  logic        s_done,
  output logic        instr_ready,
  output logic [31:0] cur_instr,
  output logic [2:0]  cur_unit,
  output logic        unit_start,
  output logic        wb_en,
  output logic        retire,
  output logic        busy,
  output logic        timeout_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state, state_nx;
  logic [34:0] head;
  logic [CW-1:0] count;
  logic [7:0] done_vec;
  logic full, empty, pop, done_hit, tmo, timed_out;
  unit_e cur_u;
  assign cur_u = unit_e'(cur_unit);
  assign pop = state == S_IDLE && !empty;
  // index by unit_sel; CONFIG and NONE never complete through a done line
  assign done_vec = {1'b0, s_done, l_done, done_vred, done_vsldu, done_vmul, done_valu, 1'b0};
  assign done_hit = done_vec[cur_unit];
  v_issue_fifo #(.WIDTH(35), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .rst(nrst),
    .push(instr_valid && instr_ready),
    .pop,
    .wdata({instr, unit_sel}),
    .rdata(head),
    .full,
    .empty,
    .count
  );
`ifdef CARRD_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign tmo = wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge nrst)
    if (nrst) begin
      wait_cnt <= '0;
      timed_out <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= state == S_WAIT ? wait_cnt + 1'b1 : '0;
      timed_out <= state == S_WAIT && tmo && !done_hit;
      timeout_err <= timeout_err | (state == S_WAIT && tmo && !done_hit);
    end
`else
  assign tmo = 1'b0;
  assign timed_out = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge nrst)
    if (nrst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = empty ? S_IDLE : S_ISSUE;
      S_ISSUE: state_nx = (cur_u == U_CONFIG || cur_u == U_NONE) ? S_WB : S_WAIT;
      S_WAIT:  state_nx = (done_hit || tmo) ? S_WB : S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge nrst)
    if (nrst) begin
      cur_instr <= '0;
      cur_unit <= '0;
    end else if (pop) begin
      cur_instr <= head[34:3];
      cur_unit <= head[2:0];
    end else if (state == S_WB) begin
      cur_instr <= '0;
      cur_unit <= '0;
    end
  always_comb begin
    instr_ready = !full;
    unit_start = state == S_ISSUE;
    retire = state == S_WB;
    wb_en = retire && writes_back(cur_u) && !timed_out;
    busy = state != S_IDLE || |count;
  end
endmodule

// File: tb/tb_v_issue_seq.sv
// tb_v_issue_seq: randomized scoreboard bench for v_issue_seq against a cycle-level issue model.
module tb_v_issue_seq;
  localparam int DEPTH = 2;
  localparam int TMO = 8;
`ifdef CARRD_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] ins;
    logic [2:0] u;
    bit hang;
    int dly;
    int pcyc;
  } ent_t;
  logic clk, nrst, instr_valid;
  logic [31:0] instr, cur_instr;
  logic [2:0] unit_sel, cur_unit;
  logic [6:1] dv;
  logic instr_ready, unit_start, wb_en, retire, busy, timeout_err;
  ent_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int start_cyc = 0, exp_lat = 0, done_at = -1, last_ret = -10, tgt = 0, d = 0;
  bit inflight = 1'b0, err_exp = 1'b0, es, er, wbx;

  v_issue_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .instr(instr), .unit_sel(unit_sel),
    .done_valu(dv[1]), .done_vmul(dv[2]), .done_vsldu(dv[3]), .done_vred(dv[4]),
    .l_done(dv[5]), .s_done(dv[6]),
    .instr_ready(instr_ready), .cur_instr(cur_instr), .cur_unit(cur_unit),
    .unit_start(unit_start), .wb_en(wb_en), .retire(retire), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: an entry issues two cycles after both its push and the previous retire;
  // it retires one cycle after ISSUE (CONFIG/NONE), one cycle after its done, or after the watchdog.
  initial forever begin
    @(negedge clk);
    cyc++;
    dv = 6'($urandom);
    if (inflight && tgt >= 1 && tgt <= 6) dv[tgt] = (cyc == done_at);
    #1;
    if (nrst) begin
      q.delete();
      inflight = 1'b0;
      err_exp = 1'b0;
      done_at = -1;
      last_ret = -10;
      chk("rst_instr_ready", instr_ready, 1);
      chk("rst_cur_instr", cur_instr, 0);
      chk("rst_cur_unit", cur_unit, 0);
      chk("rst_unit_start", unit_start, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_retire", retire, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
    end else begin
      es = !inflight && q.size() > 0 &&
           cyc >= ((q[0].pcyc > last_ret ? q[0].pcyc : last_ret) + 2);
      chk("unit_start", unit_start, es);
      if (es) begin
        inflight = 1'b1;
        start_cyc = cyc;
        tgt = q[0].u;
        done_at = -1;
        if (q[0].hang) exp_lat = TMO_EN ? TMO + 1 : 1 << 30;
        else if (tgt == 0 || tgt == 7) exp_lat = 1;
        else begin
          d = q[0].dly >= 0 ? q[0].dly : $urandom_range(0, 4);
          done_at = cyc + 1 + d;
          exp_lat = 2 + d;
        end
      end
      chk("cur_instr", cur_instr, inflight ? q[0].ins : 32'd0);
      chk("cur_unit", cur_unit, inflight ? q[0].u : 3'd0);
      er = inflight && cyc == start_cyc + exp_lat;
      wbx = er && !q[0].hang && q[0].u != 6 && q[0].u != 7;
      chk("retire", retire, er);
      chk("wb_en", wb_en, wbx);
      chk("busy", busy, q.size() > 0);
      chk("instr_ready", instr_ready, (q.size() - int'(inflight)) < DEPTH);
      if (er && q[0].hang) err_exp = 1'b1;
      chk("timeout_err", timeout_err, err_exp);
      if (er) begin
        void'(q.pop_front());
        inflight = 1'b0;
        last_ret = cyc;
      end
    end
  end

  task automatic push_i(input logic [31:0] ins, input logic [2:0] u, input bit hang, input int dly);
    bit acc = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = ins;
    unit_sel = u;
    for (int k = 0; k < 200; k++) begin
      acc = instr_ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    chk("push_accept", acc, 1);
    if (acc) q.push_back('{ins, u, hang, dly, cyc});
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && q.size() > 0; k++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    nrst = 1'b1;
    repeat (n) @(negedge clk);
    nrst = 1'b0;
  endtask

  initial begin
    nrst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    unit_sel = '0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    push_i(32'h0000_7057, 3'd0, 1'b0, -1);
    drain();
    push_i($urandom, 3'd1, 1'b0, 5);
    drain();
    push_i($urandom, 3'd1, 1'b0, 6);
    push_i($urandom, 3'd2, 1'b0, -1);
    push_i($urandom, 3'd3, 1'b0, -1);
    drain();
    push_i($urandom, 3'd6, 1'b0, 0);
    drain();
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_i($urandom, 3'($urandom), 1'b0, -1);
    end
    drain();
`ifdef CARRD_SEQ_TIMEOUT_EN
    push_i($urandom, 3'd2, 1'b1, -1);
    drain();
    repeat (3) @(negedge clk);
    push_i($urandom, 3'd2, 1'b1, -1);
`else
    push_i($urandom, 3'd2, 1'b1, -1);
    repeat (20) @(negedge clk);
`endif
    push_i($urandom, 3'd1, 1'b0, -1);
    push_i($urandom, 3'd5, 1'b0, -1);
    repeat (2) @(negedge clk);
    do_reset(3);
    repeat (2) @(negedge clk);
    push_i($urandom, 3'd0, 1'b0, -1);
    push_i($urandom, 3'd4, 1'b0, -1);
    push_i($urandom, 3'd7, 1'b0, -1);
    drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
